sdram_device_model: RTL

Synthesizable responder for the SDRAM chip-side bus driven by `SDRAM_controller_verilog`. It decodes the controller's commands, tracks open rows per bank and stores write data in a parameter-sized internal array. It returns read data on the bidirectional data bus after the programmed CAS latency. Benches and FPGA loopback builds instantiate it in place of the physical SDRAM, and it flags protocol violations.

---
 rtl/sdram_pkg.sv | 47 ++++
 rtl/sdram_device_model_if.sv | 23 ++
 rtl/sdram_rd_pipe.sv | 54 +++++
 rtl/sdram_device_model.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM device model: command encodings,
// error codes, CAS latency bounds and bus geometry.
package sdram_pkg;

   localparam int SD_ROW_W  = 13;
   localparam int SD_COL_W  = 10;
   localparam int SD_BANK_W = 2;
   localparam int SD_NBANK  = 4;
   localparam int SD_DATA_W = 16;
   localparam int SD_CL_MIN = 2;
   localparam int SD_CL_MAX = 3;

   // Encoded as {RAS_n, CAS_n, WE_n}.
   typedef enum logic [2:0] {
      CMD_LMR   = 3'b000,
      CMD_AREF  = 3'b001,
      CMD_PRE   = 3'b010,
      CMD_ACT   = 3'b011,
      CMD_WRITE = 3'b100,
      CMD_READ  = 3'b101,
      CMD_RSVD  = 3'b110,
      CMD_NOP   = 3'b111
   } sdram_cmd_t;

   typedef enum logic [2:0] {
      ERR_NONE        = 3'd0,
      ERR_NOT_INIT    = 3'd1,
      ERR_CLOSED_BANK = 3'd2,
      ERR_OPEN_BANK   = 3'd3,
      ERR_BAD_MODE    = 3'd4,
      ERR_REF_OPEN    = 3'd5,
      ERR_EARLY_LMR   = 3'd6
   } sdram_err_t;

   typedef enum logic [2:0] {
      INIT_WAIT_PALL,
      INIT_REF0,
      INIT_REF1,
      INIT_READY,
      INIT_DONE
   } init_state_t;

   function automatic logic cl_legal(input logic [2:0] cl);
      return (cl >= 3'(SD_CL_MIN)) && (cl <= 3'(SD_CL_MAX));
   endfunction

endpackage

// File: rtl/sdram_device_model_if.sv
// Controller-to-chip command/address/mask bus. The data bus is a separate
// inout port on the device because it is bidirectional.
interface sdram_device_model_if;
   logic        sdCke_o;
   logic        sdCe_bo;
   logic        sdRas_bo;
   logic        sdCas_bo;
   logic        sdWe_bo;
   logic [1:0]  sdBs_o;
   logic [12:0] sdAddr_o;
   logic        sdDqmu_o;
   logic        sdDqml_o;

   modport master (
      output sdCke_o, sdCe_bo, sdRas_bo, sdCas_bo, sdWe_bo,
             sdBs_o, sdAddr_o, sdDqmu_o, sdDqml_o
   );

   modport slave (
      input  sdCke_o, sdCe_bo, sdRas_bo, sdCas_bo, sdWe_bo,
             sdBs_o, sdAddr_o, sdDqmu_o, sdDqml_o
   );
endinterface

// File: rtl/sdram_rd_pipe.sv
// Read-data delay line: three stages of data plus byte enables; the CAS
// latency selects which stage feeds the tri-state drivers.
module sdram_rd_pipe
   import sdram_pkg::*;
#(
   parameter int DATA_W = SD_DATA_W
) (
   input  logic              clk_200MHz_i,
   input  logic              reset_bi,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic [1:0]        be_in,
   input  logic [2:0]        cl,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        oe
);

   logic [DATA_W-1:0] data_p0, data_p1, data_p2;
   logic [1:0]        be_p0, be_p1, be_p2;
   logic              vld_p0, vld_p1, vld_p2;

   // Only the valid bits are reset, so an asynchronous reset releases the bus at once.
   always_ff @(posedge clk_200MHz_i or negedge reset_bi) begin
      if (!reset_bi) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= push;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // Stage p0: loaded on the READ edge; p1/p2: one and two edges later.
   always_ff @(posedge clk_200MHz_i) begin
      data_p0 <= din;
      be_p0   <= be_in;
      data_p1 <= data_p0;
      be_p1   <= be_p0;
      data_p2 <= data_p1;
      be_p2   <= be_p1;
   end

   always_comb begin
      dout = data_p2;
      oe   = vld_p2 ? be_p2 : 2'b00;
      if (cl == 3'd2) begin
         dout = data_p1;
         oe   = vld_p1 ? be_p1 : 2'b00;
      end
   end

endmodule

// File: rtl/sdram_device_model.sv
// SDRAM chip stand-in: command decode, per-bank open-row tracking, storage
// array and CAS-latency read return. Define SDRAM_MODEL_CHECK_EN for the protocol checker.
module sdram_device_model
   import sdram_pkg::*;
#(
   parameter int MEM_AW   = 12,
   parameter int CL_RESET = 3
) (
   input  logic                 clk_200MHz_i,
   input  logic                 reset_bi,
   sdram_device_model_if.slave  sd,
   inout  wire  [SD_DATA_W-1:0] sdData_io,
   output logic                 init_done_o,
   output logic [15:0]          refresh_cnt_o,
   output logic                 err_o,
   output logic [2:0]           err_code_o
);

   sdram_cmd_t            cmd;
   logic [SD_BANK_W-1:0]  bs;
   logic [SD_ROW_W-1:0]   addr;
   logic                  a10;
   logic                  mode_ok;
   logic                  lmr_init;
   logic [SD_NBANK-1:0]   bank_open;
   logic [SD_ROW_W-1:0]   bank_row [SD_NBANK];
   logic [2:0]            cl_q;
   logic [MEM_AW-1:0]     mem_idx;
   logic [SD_DATA_W-1:0]  mem [2**MEM_AW];
   logic [SD_DATA_W-1:0]  rd_dout;
   logic [1:0]            dq_oe;

   assign cmd     = (sd.sdCke_o && !sd.sdCe_bo)
                    ? sdram_cmd_t'({sd.sdRas_bo, sd.sdCas_bo, sd.sdWe_bo}) : CMD_NOP;
   assign bs      = sd.sdBs_o;
   assign addr    = sd.sdAddr_o;
   assign a10     = addr[10];
   assign mode_ok = (addr[2:0] == 3'b000) && cl_legal(addr[6:4]);
   // A closed bank still resolves through the last row it held.
   assign mem_idx = MEM_AW'({bs, bank_row[bs], addr[SD_COL_W-1:0]});

   always_ff @(posedge clk_200MHz_i or negedge reset_bi) begin
      if (!reset_bi) begin
         bank_open <= '0;
      end else begin
         case (cmd)
            CMD_ACT: bank_open[bs] <= 1'b1;
            CMD_PRE: begin
               if (a10) bank_open <= '0;
               else     bank_open[bs] <= 1'b0;
            end
            CMD_READ, CMD_WRITE: if (a10) bank_open[bs] <= 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_200MHz_i) begin
      if (cmd == CMD_ACT) bank_row[bs] <= addr;
   end

   always_ff @(posedge clk_200MHz_i or negedge reset_bi) begin
      if (!reset_bi) begin
         cl_q          <= 3'(CL_RESET);
         init_done_o   <= 1'b0;
         refresh_cnt_o <= '0;
      end else begin
         if (cmd == CMD_LMR && mode_ok)  cl_q        <= addr[6:4];
         if (cmd == CMD_LMR && lmr_init) init_done_o <= 1'b1;
         if (cmd == CMD_AREF && refresh_cnt_o != 16'hFFFF)
            refresh_cnt_o <= refresh_cnt_o + 16'd1;
      end
   end

   // DQM high protects its byte from the write.
   always_ff @(posedge clk_200MHz_i) begin
      if (cmd == CMD_WRITE) begin
         if (!sd.sdDqml_o) mem[mem_idx][7:0]  <= sdData_io[7:0];
         if (!sd.sdDqmu_o) mem[mem_idx][15:8] <= sdData_io[15:8];
      end
   end

   sdram_rd_pipe #(.DATA_W(SD_DATA_W)) u_rd_pipe (
      .clk_200MHz_i (clk_200MHz_i),
      .reset_bi     (reset_bi),
      .push         (cmd == CMD_READ),
      .din          (mem[mem_idx]),
      .be_in        ({~sd.sdDqmu_o, ~sd.sdDqml_o}),
      .cl           (cl_q),
      .dout         (rd_dout),
      .oe           (dq_oe)
   );

   assign sdData_io[15:8] = dq_oe[1] ? rd_dout[15:8] : 8'hzz;
   assign sdData_io[7:0]  = dq_oe[0] ? rd_dout[7:0]  : 8'hzz;

`ifdef SDRAM_MODEL_CHECK_EN
   init_state_t init_st, init_nxt;
   sdram_err_t  err_now;

   assign lmr_init = mode_ok;

   always_ff @(posedge clk_200MHz_i or negedge reset_bi) begin
      if (!reset_bi) init_st <= INIT_WAIT_PALL;
      else           init_st <= init_nxt;
   end

   // Tracks PRECHARGE-all followed by two AUTO REFRESH before the mode load.
   always_comb begin
      init_nxt = init_st;
      if (cmd == CMD_LMR && mode_ok) begin
         init_nxt = INIT_DONE;
      end else begin
         case (init_st)
            INIT_WAIT_PALL: if (cmd == CMD_PRE && a10) init_nxt = INIT_REF0;
            INIT_REF0:      if (cmd == CMD_AREF)       init_nxt = INIT_REF1;
            INIT_REF1:      if (cmd == CMD_AREF)       init_nxt = INIT_READY;
            default: ;
         endcase
      end
   end

   always_comb begin
      err_now = ERR_NONE;
      if ((cmd == CMD_ACT || cmd == CMD_READ || cmd == CMD_WRITE) && !init_done_o)
         err_now = ERR_NOT_INIT;
      else if ((cmd == CMD_READ || cmd == CMD_WRITE) && !bank_open[bs])
         err_now = ERR_CLOSED_BANK;
      else if (cmd == CMD_ACT && bank_open[bs])
         err_now = ERR_OPEN_BANK;
      else if (cmd == CMD_LMR && !mode_ok)
         err_now = ERR_BAD_MODE;
      else if (cmd == CMD_AREF && (|bank_open))
         err_now = ERR_REF_OPEN;
      else if (cmd == CMD_LMR && init_st != INIT_READY && init_st != INIT_DONE)
         err_now = ERR_EARLY_LMR;
   end

   always_ff @(posedge clk_200MHz_i or negedge reset_bi) begin
      if (!reset_bi) begin
         err_o      <= 1'b0;
         err_code_o <= 3'd0;
      end else if (!err_o && err_now != ERR_NONE) begin
         err_o      <= 1'b1;
         err_code_o <= err_now;
      end
   end
`else
   assign lmr_init   = 1'b1;
   assign err_o      = 1'b0;
   assign err_code_o = 3'd0;
`endif

endmodule
